demux2_buf: RTL
===============

# demux2_buf

Buffered 1-to-2 demultiplexer: the receive-side counterpart of the team's 2:1 multiplexer. It takes one WIDTH-bit input stream with a per-word select bit and routes each accepted word to output channel A (select 0) or channel B (select 1). Each channel has its own DEPTH-entry FIFO with a valid/ready handshake. It sits after a shared datapath bus and splits traffic back into two independent consumers, so a stalled consumer on one channel never blocks the other.

## Interface
- WIDTH, 4, data width of input and both outputs
- DEPTH, 2, entries per channel FIFO; power of two, ≥ 2
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  reset, synchronous, active-high
- in_data  input  WIDTH  input word
- in_sel  input  1  destination: 0 → channel A, 1 → channel B
- in_valid  input  1  producer offers in_data/in_sel this cycle
- in_ready  output  1  block accepts the offered word this cycle
- a_data  output  WIDTH  head word of FIFO A
- a_valid  output  1  FIFO A non-empty
- a_ready  input  1  consumer A takes a_data this cycle
- b_data  output  WIDTH  head word of FIFO B
- b_valid  output  1  FIFO B non-empty
- b_ready  input  1  consumer B takes b_data this cycle

## Operation
- Push: an input transfer occurs when in_valid && in_ready. The word is written into FIFO A if in_sel=0 and into FIFO B if in_sel=1. Exactly one FIFO is written per transfer.
- in_ready is combinational: FIFO A not full when in_sel=0, FIFO B not full when in_sel=1. It is independent of in_valid.
- A full FIFO drives in_ready low for its select value, even when a pop occurs in the same cycle. There is no full-cycle pass-through.
- Pop: channel X transfers when x_valid && x_ready. Its read pointer advances and its count decrements.
- x_ready while x_valid=0 is ignored. in_valid while in_ready=0 is ignored; the producer must hold its word.
- Each FIFO keeps a storage array, read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH, and a count of log2(DEPTH)+1 bits ranging 0..DEPTH.
- x_valid = (count_x != 0). x_data = storage_x[rd_ptr_x].
- Simultaneous push and pop on the same FIFO with 0 < count < DEPTH: both happen and the count is unchanged.
- Simultaneous push to one FIFO and pop from the other: independent.
- Ordering: per channel, output order equals acceptance order. There is no ordering guarantee between channels.
- The input stream is never lost or duplicated.

## Timing
- Reset (rst=1 at a rising edge): all counts and pointers go to 0 and all storage goes to 0.
- Reset values of outputs:
  - a_valid=0, b_valid=0
  - a_data=0, b_data=0
  - in_ready=1
- Reset mid-operation discards all buffered words. rst takes precedence over any push or pop in the same cycle.
- Latency: a word accepted at edge N is visible on x_data with x_valid=1 after edge N (1 cycle) when its FIFO was empty.
- Sustained throughput is 1 word/cycle per channel when the consumer holds x_ready=1.
- All outputs other than in_ready are registered state or are read directly from registered storage.

## Test plan
- Basic routing: after reset, push 4'b1010 with sel=0, then 4'b0010 with sel=1 → a_valid=1 and a_data=1010 the cycle after the first push; b_valid=1 and b_data=0010 the cycle after the second; each valid deasserts one cycle after its consumer pops.
- Full/backpressure: a_ready=0, push 0001 and 0010 with sel=0 → count_A=2 and in_ready=0 with sel=0. Switching to sel=1 gives in_ready=1 and 0011 lands in B. Raise a_ready → A drains 0001 then 0010.
- Full plus simultaneous pop: with A full, a_ready=1 and in_valid=1, sel=0 → the pop occurs, no push, in_ready=0 that cycle and 1 the next.
- Concurrent push/pop with wrap-around: stream 0000..1111 to A with a_ready=1 continuously → a_data outputs all 16 values in order at 1 word/cycle, with pointers wrapping ≥ 4 times.
- Reset mid-operation: A holds 0101, B holds 0110, assert rst with in_valid=1 → next cycle a_valid=b_valid=0, data=0, in_ready=1, and the pushed word is not stored.

Source files
------------

// File: rtl/demux2_buf_if.sv
// Bundle of the demultiplexer's stream signals: one producer-side input
// stream with a per-word select, and two consumer-side output channels.
interface demux2_buf_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;

  // Environment side: drives the input stream and both consumer readies.
  modport master (
    output in_data, in_sel, in_valid, a_ready, b_ready,
    input  in_ready, a_data, a_valid, b_data, b_valid
  );

  // Block side: accepts the input stream and presents both channels.
  modport slave (
    input  in_data, in_sel, in_valid, a_ready, b_ready,
    output in_ready, a_data, a_valid, b_data, b_valid
  );
endinterface

// File: rtl/demux2_buf.sv
// Buffered 1-to-2 demultiplexer. Each accepted word is steered by in_sel
// into one of two independent DEPTH-entry FIFOs, so a stalled consumer on
// one channel never blocks traffic headed for the other.
module demux2_buf #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input logic        clk,
  input logic        rst,
  demux2_buf_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW-1:0]    wr_ptr_a, rd_ptr_a;
  logic [AW-1:0]    wr_ptr_b, rd_ptr_b;
  logic [AW:0]      cnt_a, cnt_b;

  logic full_a, full_b;
  logic push_a, push_b;
  logic pop_a, pop_b;
  logic ready;

  // Handshake decode: readiness depends only on the selected FIFO's fill
  // level, so a full FIFO refuses a push even while it is being popped.
  always_comb begin
    full_a = (cnt_a == CNT_FULL);
    full_b = (cnt_b == CNT_FULL);
    ready  = bus.in_sel ? !full_b : !full_a;
    push_a = bus.in_valid && ready && !bus.in_sel;
    push_b = bus.in_valid && ready &&  bus.in_sel;
    pop_a  = (cnt_a != '0) && bus.a_ready;
    pop_b  = (cnt_b != '0) && bus.b_ready;
  end

  assign bus.in_ready = ready;
  assign bus.a_valid  = (cnt_a != '0);
  assign bus.b_valid  = (cnt_b != '0);
  assign bus.a_data   = mem_a[rd_ptr_a];
  assign bus.b_data   = mem_b[rd_ptr_b];

  // FIFO A: storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_a <= '0;
      rd_ptr_a <= '0;
      cnt_a    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_a[i] <= '0;
    end else begin
      if (push_a) begin
        mem_a[wr_ptr_a] <= bus.in_data;
        wr_ptr_a        <= wr_ptr_a + 1'b1;
      end
      if (pop_a) rd_ptr_a <= rd_ptr_a + 1'b1;
      case ({push_a, pop_a})
        2'b10:   cnt_a <= cnt_a + 1'b1;
        2'b01:   cnt_a <= cnt_a - 1'b1;
        default: cnt_a <= cnt_a;
      endcase
    end
  end

  // FIFO B: storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_b <= '0;
      rd_ptr_b <= '0;
      cnt_b    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_b[i] <= '0;
    end else begin
      if (push_b) begin
        mem_b[wr_ptr_b] <= bus.in_data;
        wr_ptr_b        <= wr_ptr_b + 1'b1;
      end
      if (pop_b) rd_ptr_b <= rd_ptr_b + 1'b1;
      case ({push_b, pop_b})
        2'b10:   cnt_b <= cnt_b + 1'b1;
        2'b01:   cnt_b <= cnt_b - 1'b1;
        default: cnt_b <= cnt_b;
      endcase
    end
  end
endmodule
